// File: rtl/parity_gen_chk.sv
// -----------------------------------------------------------------------------
// parity_gen_chk
//
// Pipelined even/odd parity generator and checker.
//
// The generator path takes DATA_W-bit words over a valid/ready handshake and
// presents {parity, payload} from a one-entry output register. The checker
// path takes {parity, payload} words every cycle they are valid. It reports
// a registered pass/fail pulse, keeps a saturating error counter, and keeps a
// sticky error flag.
//
// Parameters
//   DATA_W      payload width in bits (>= 1)
//   CNT_W       error-counter width in bits (>= 1)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous, active-high reset
//   mode        0 = even parity, 1 = odd parity (sampled per word, both paths)
//   err_inject  inverts the generated parity bit of the word being accepted
//   in_valid    generator input word valid
//   in_ready    generator can accept a word (combinational)
//   in_data     generator payload
//   out_valid   generator output word valid
//   out_ready   downstream accepts the output word
//   out_data    {parity, payload}, parity in the MSB
//   chk_valid   checker input word valid (always accepted)
//   chk_data    {parity, payload} to be checked
//   chk_done    one-cycle pulse, a check result is present
//   chk_err     parity error for the word reported by chk_done
//   err_sticky  set by any counted error, cleared by clr_count or rst
//   err_count   saturating count of checker errors
//   clr_count   synchronous clear of err_count and err_sticky
// -----------------------------------------------------------------------------
module parity_gen_chk #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              err_inject,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_data,
    input  logic              chk_valid,
    input  logic [DATA_W:0]   chk_data,
    output logic              chk_done,
    output logic              chk_err,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    input  logic              clr_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Generator path
    // -------------------------------------------------------------------------
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W:0]   out_data_q;
    logic [DATA_W:0]   out_data_d;
    logic              gen_parity;
    logic              gen_accept;
    logic              gen_drain;

    // Odd parity is the complement of even parity. The test hook flips the
    // result once more, so a single XOR chain covers all four cases.
    always_comb begin
        gen_parity = (^in_data) ^ mode ^ err_inject;
    end

    // The register can take a new word when it is empty or is being emptied
    // this cycle. in_valid deliberately plays no part here.
    always_comb begin
        in_ready   = !out_valid_q || out_ready;
        gen_accept = in_valid && in_ready;
        gen_drain  = out_valid_q && out_ready;
    end

    // An accept overrides a drain: a coincident drain and accept replaces the
    // word with no bubble. Otherwise a held word is frozen, so later changes to
    // mode or err_inject cannot reach it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (gen_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = {gen_parity, in_data};
        end else if (gen_drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // -------------------------------------------------------------------------
    // Checker path
    // -------------------------------------------------------------------------
    logic              chk_done_q;
    logic              chk_done_d;
    logic              chk_err_q;
    logic              chk_err_d;
    logic              err_sticky_q;
    logic              err_sticky_d;
    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;
    logic              word_bad;
    logic              count_event;

    // The XOR of the whole word, parity included, must equal mode. Even parity
    // expects 0 and odd parity expects 1.
    always_comb begin
        word_bad = (^chk_data) != mode;
    end

    always_comb begin
        chk_done_d  = chk_valid;
        chk_err_d   = chk_valid && word_bad;
        // A clear wins over a coincident error. The error is still reported
        // on chk_err, but it is neither counted nor made sticky.
        count_event = chk_err_d && !clr_count;
    end

    always_comb begin
        err_count_d  = err_count_q;
        err_sticky_d = err_sticky_q;
        if (clr_count) begin
            err_count_d  = '0;
            err_sticky_d = 1'b0;
        end else if (count_event) begin
            err_sticky_d = 1'b1;
            // Saturate at all-ones instead of wrapping back to zero.
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_done_q   <= 1'b0;
            chk_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            chk_done_q   <= chk_done_d;
            chk_err_q    <= chk_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign chk_done   = chk_done_q;
    assign chk_err    = chk_err_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
module tb_parity_gen_chk;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              mode;
    logic              err_inject;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_data;
    logic              chk_valid;
    logic [DATA_W:0]   chk_data;
    logic              chk_done;
    logic              chk_err;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_count;
    logic              clr_count;

    int checks;
    int errors;

    parity_gen_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .err_inject (err_inject),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .chk_valid  (chk_valid),
        .chk_data   (chk_data),
        .chk_done   (chk_done),
        .chk_err    (chk_err),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .clr_count  (clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The parity bit makes the total number of ones in the word even (mode 0)
    // or odd (mode 1). err_inject flips it.
    function automatic logic [DATA_W:0] gen_model(input logic [DATA_W-1:0] d,
                                                  input logic m, input logic inj);
        int ones;
        logic p;
        ones = $countones(d);
        p = ((ones % 2) != (m ? 1 : 0)) ? 1'b1 : 1'b0;
        return {p ^ inj, d};
    endfunction

    function automatic logic chk_model(input logic [DATA_W:0] w, input logic m);
        int ones;
        ones = $countones(w);
        return ((ones % 2) != (m ? 1 : 0)) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              m;
        logic              inj;
        logic [DATA_W:0]   exp;
    } gen_vec_t;

    typedef struct {
        logic [DATA_W:0] word;
        logic            m;
        logic            exp_err;
    } chk_vec_t;

    gen_vec_t gen_tbl [5];
    chk_vec_t chk_tbl [3];
    int       sat_seq [6];
    logic [DATA_W-1:0] words [16];
    logic [DATA_W:0]   exp_q [$];
    logic [DATA_W:0]   exp_w;
    int model_cnt;
    logic model_sticky;
    int sent;
    int drained;

    initial begin
        checks = 0;
        errors = 0;

        gen_tbl[0] = '{8'hA7, 1'b0, 1'b0, 9'h1A7};
        gen_tbl[1] = '{8'hA7, 1'b1, 1'b0, 9'h0A7};
        gen_tbl[2] = '{8'h00, 1'b0, 1'b0, 9'h000};
        gen_tbl[3] = '{8'h00, 1'b1, 1'b0, 9'h100};
        gen_tbl[4] = '{8'hA7, 1'b0, 1'b1, 9'h0A7};

        chk_tbl[0] = '{9'h1A7, 1'b0, 1'b0};
        chk_tbl[1] = '{9'h0A7, 1'b0, 1'b1};
        chk_tbl[2] = '{9'h0A7, 1'b1, 1'b0};

        sat_seq[0] = 1; sat_seq[1] = 2; sat_seq[2] = 3;
        sat_seq[3] = 3; sat_seq[4] = 3; sat_seq[5] = 3;

        rst = 1'b1;
        mode = 1'b0;
        err_inject = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        chk_valid = 1'b0;
        chk_data = '0;
        clr_count = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_chk_done", chk_done, 0);
        check("rst_chk_err", chk_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // ---------------- generator table ----------------
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_data    = gen_tbl[i].data;
            mode       = gen_tbl[i].m;
            err_inject = gen_tbl[i].inj;
            out_ready  = 1'b1;
            tick();
            $display("gen vec %0d data=0x%0h mode=%0d inj=%0d out=0x%0h", i,
                     gen_tbl[i].data, gen_tbl[i].m, gen_tbl[i].inj, out_data);
            check("gen_out_valid", out_valid, 1);
            check("gen_out_data", out_data, gen_tbl[i].exp);
        end
        in_valid = 1'b0;
        err_inject = 1'b0;
        tick();
        check("gen_idle_valid", out_valid, 0);

        // ---------------- backpressure ----------------
        in_valid = 1'b1;
        in_data  = 8'h11;
        mode     = 1'b1;
        tick();
        check("bp_first_word", out_data, 9'h111);
        out_ready = 1'b0;
        in_data   = 8'h22;
        mode      = 1'b0;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            $display("bp hold cycle %0d out=0x%0h", i, out_data);
            check("bp_hold_data", out_data, 9'h111);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_back", in_ready, 1);
        tick();
        check("bp_replace_data", out_data, 9'h022);
        check("bp_replace_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("bp_drained", out_valid, 0);

        // ---------------- checker table ----------------
        model_cnt = 0;
        model_sticky = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_valid = 1'b1;
            chk_data  = chk_tbl[i].word;
            mode      = chk_tbl[i].m;
            tick();
            if (chk_model(chk_tbl[i].word, chk_tbl[i].m)) begin
                if (model_cnt < CNT_SAT) model_cnt++;
                model_sticky = 1'b1;
            end
            $display("chk vec %0d word=0x%0h mode=%0d err=%0d cnt=%0d", i,
                     chk_tbl[i].word, chk_tbl[i].m, chk_err, err_count);
            check("chk_done", chk_done, 1);
            check("chk_err", chk_err, chk_tbl[i].exp_err);
            check("chk_count", err_count, model_cnt);
            check("chk_sticky", err_sticky, model_sticky);
        end
        chk_valid = 1'b0;
        tick();
        check("chk_done_idle", chk_done, 0);
        check("chk_err_idle", chk_err, 0);

        // ---------------- saturation and clear ----------------
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clr_count", err_count, 0);
        check("clr_sticky", err_sticky, 0);
        mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_valid = 1'b1;
            chk_data  = 9'h0A7;
            tick();
            $display("sat word %0d cnt=%0d", i, err_count);
            check("sat_count", err_count, sat_seq[i]);
        end
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check("clrbad_err", chk_err, 1);
        check("clrbad_count", err_count, 0);
        check("clrbad_sticky", err_sticky, 0);
        tick();
        check("after_clr_count", err_count, 1);
        check("after_clr_sticky", err_sticky, 1);

        // ---------------- reset mid-operation ----------------
        clr_count = 1'b1;
        chk_valid = 1'b0;
        tick();
        clr_count = 1'b0;
        chk_valid = 1'b1;
        chk_data  = 9'h0A7;
        tick();
        tick();
        chk_valid = 1'b0;
        check("pre_rst_count", err_count, 2);
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_count", err_count, 0);
        check("async_rst_sticky", err_sticky, 0);
        check("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_no_word", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        mode      = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_word", out_data, gen_model(8'h5A, 1'b1, 1'b0));
        check("post_rst_word_valid", out_valid, 1);
        tick();

        // ---------------- concurrency with loopback ----------------
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        for (int i = 0; i < 16; i++) words[i] = DATA_W'($urandom);
        mode = 1'($urandom_range(0, 1));
        sent = 0;
        drained = 0;
        for (int cyc = 0; cyc < 400 && drained < 16; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 16) && ($urandom_range(0, 3) != 0);
            in_data   = (sent < 16) ? words[sent] : '0;
            chk_valid = out_valid && out_ready;
            chk_data  = out_data;
            #1;
            check("stream_in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_word", out_valid, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    $display("stream word %0d out=0x%0h exp=0x%0h", drained, out_data, exp_w);
                    check("stream_word", out_data, exp_w);
                end
                drained++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(gen_model(in_data, mode, 1'b0));
                sent++;
            end
            @(posedge clk);
            #1;
            if (chk_done) check("loop_chk_err", chk_err, 0);
        end
        in_valid  = 1'b0;
        chk_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", sent, 16);
        check("stream_drained", drained, 16);
        check("stream_queue_empty", exp_q.size(), 0);
        tick();
        check("stream_no_extra", out_valid, 0);
        check("loop_err_count", err_count, 0);
        check("loop_err_sticky", err_sticky, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
